bshifter_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter with valid/ready handshake.

---
 rtl/bshifter_pipe_if.sv | 29 ++
 rtl/bshifter_pipe.sv | 113 +++++++++++
 tb/tb_bshifter_pipe.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bshifter_pipe_if.sv
// Handshake and operand/result bundle for bshifter_pipe.
// master drives operands and out_ready; slave is the shifter's view.
interface bshifter_pipe_if #(
   parameter int WIDTH = 8
);
   localparam int AW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] val;
   logic [AW-1:0]    amt;
   logic             ssl;
   logic [1:0]       mode;
   logic             i;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic             o;

   modport master (
      output in_valid, val, amt, ssl, mode, i, out_ready,
      input  in_ready, out_valid, res, o
   );

   modport slave (
      input  in_valid, val, amt, ssl, mode, i, out_ready,
      output in_ready, out_valid, res, o
   );
endinterface

// File: rtl/bshifter_pipe.sv
// Pipelined log2 barrel shifter: stage k shifts by 2^k, fill/rotate decided at entry.
// PIPELINED=0 chains all stages combinationally into a single output register.
module bshifter_pipe #(
   parameter int WIDTH     = 8,
   parameter bit PIPELINED = 1'b1
) (
   input logic            clock,
   input logic            reset,
   bshifter_pipe_if.slave bus
);
   localparam int LW   = $clog2(WIDTH);
   localparam int NREG = PIPELINED ? LW : 1;

   logic              adv;
   logic [NREG-1:0]   vld_q;
   logic [WIDTH-1:0]  res_q;
   logic              o_q;

   assign adv           = !vld_q[NREG-1] || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_q[NREG-1];
   assign bus.res       = res_q;
   assign bus.o         = o_q;

   // Rotate feeds the operand itself in as the fill source; otherwise a constant fill bit.
   function automatic logic [WIDTH-1:0] shf(input logic [WIDTH-1:0] d, input int unsigned s,
                                            input logic right, input logic rot, input logic fill);
      logic [2*WIDTH-1:0] t;
      logic [WIDTH-1:0]   fv;
      fv = rot ? d : {WIDTH{fill}};
      if (right) begin
         t   = {fv, d} >> s;
         shf = t[WIDTH-1:0];
      end else begin
         t   = {d, fv} << s;
         shf = t[2*WIDTH-1:WIDTH];
      end
   endfunction

   for (genvar k = 0; k < LW; k++) begin : g_st
      localparam int unsigned SH = 1 << k;
      logic [WIDTH-1:0] d_in, d_sh;
      logic [LW-1:k]    amt_in;
      logic             ssl_in, rot_in, fill_in, o_in;

      if (k == 0) begin : g_src
         logic [LW-1:0] amt_m1, amt_neg;
         assign amt_m1  = bus.amt - LW'(1);
         assign amt_neg = LW'(~bus.amt) + LW'(1);
         assign d_in    = bus.val;
         assign amt_in  = bus.amt;
         assign ssl_in  = bus.ssl;
         assign rot_in  = (bus.mode == 2'b10);
         // Arithmetic fills with the sign only when shifting right.
         assign fill_in = (bus.mode == 2'b11) ? bus.i :
                          (bus.mode == 2'b01) ? (bus.ssl & bus.val[WIDTH-1]) : 1'b0;
         assign o_in    = (bus.amt == '0) ? 1'b0 :
                          (bus.ssl ? bus.val[amt_m1] : bus.val[amt_neg]);
      end else if (PIPELINED) begin : g_reg_src
         assign d_in    = g_st[k-1].g_reg.d_q;
         assign amt_in  = g_st[k-1].g_reg.amt_q;
         assign ssl_in  = g_st[k-1].g_reg.ssl_q;
         assign rot_in  = g_st[k-1].g_reg.rot_q;
         assign fill_in = g_st[k-1].g_reg.fill_q;
         assign o_in    = g_st[k-1].g_reg.o_q;
      end else begin : g_comb_src
         assign d_in    = g_st[k-1].d_sh;
         assign amt_in  = g_st[k-1].amt_in[LW-1:k];
         assign ssl_in  = g_st[k-1].ssl_in;
         assign rot_in  = g_st[k-1].rot_in;
         assign fill_in = g_st[k-1].fill_in;
         assign o_in    = g_st[k-1].o_in;
      end

      assign d_sh = amt_in[k] ? shf(d_in, SH, ssl_in, rot_in, fill_in) : d_in;

      if (PIPELINED && (k < LW-1)) begin : g_reg
         logic [WIDTH-1:0] d_q;
         logic [LW-1:k+1]  amt_q;
         logic             ssl_q, rot_q, fill_q, o_q;
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               d_q    <= '0;
               amt_q  <= '0;
               ssl_q  <= 1'b0;
               rot_q  <= 1'b0;
               fill_q <= 1'b0;
               o_q    <= 1'b0;
            end else if (adv) begin
               d_q    <= d_sh;
               amt_q  <= amt_in[LW-1:k+1];
               ssl_q  <= ssl_in;
               rot_q  <= rot_in;
               fill_q <= fill_in;
               o_q    <= o_in;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_q <= '0;
         res_q <= '0;
         o_q   <= 1'b0;
      end else if (adv) begin
         for (int k = NREG-1; k > 0; k--) vld_q[k] <= vld_q[k-1];
         vld_q[0] <= bus.in_valid;
         res_q    <= g_st[LW-1].d_sh;
         o_q      <= g_st[LW-1].o_in;
      end
   end
endmodule

// File: tb/tb_bshifter_pipe.sv
// Directed bench for bshifter_pipe (WIDTH=8, PIPELINED=1, latency 3).
module tb_bshifter_pipe;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bshifter_pipe_if #(.WIDTH(8)) bus ();
   bshifter_pipe #(.WIDTH(8), .PIPELINED(1'b1)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] val;
      logic [2:0] amt;
      logic       ssl;
      logic [1:0] mode;
      logic       i;
      logic [7:0] res;
      logic       o;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v, input logic vld);
      bus.in_valid = vld;
      bus.val      = v.val;
      bus.amt      = v.amt;
      bus.ssl      = v.ssl;
      bus.mode     = v.mode;
      bus.i        = v.i;
   endtask

   // Sends one beat with out_ready=1, waits (bounded) for its result.
   task automatic run_one(input vec_t v, output logic [7:0] r, output logic ro, output int lat);
      bus.out_ready = 1'b1;
      drive(v, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.out_valid) chk("result_timeout", 0, 1);
      r  = bus.res;
      ro = bus.o;
   endtask

   vec_t       tbl [13];
   vec_t       v;
   logic [7:0] r, cur, walk_bits, prev_res;
   logic       ro, prev_stall;
   int         lat, sent, rcv, extra;

   initial begin
      tbl = '{
         '{8'hE6, 3'd3, 1'b1, 2'b00, 1'b0, 8'h1C, 1'b1},
         '{8'h96, 3'd2, 1'b1, 2'b01, 1'b0, 8'hE5, 1'b1},
         '{8'h96, 3'd2, 1'b1, 2'b00, 1'b0, 8'h25, 1'b1},
         '{8'h81, 3'd1, 1'b0, 2'b10, 1'b0, 8'h03, 1'b1},
         '{8'h00, 3'd4, 1'b0, 2'b11, 1'b1, 8'h0F, 1'b0},
         '{8'h5A, 3'd0, 1'b1, 2'b11, 1'b1, 8'h5A, 1'b0},
         '{8'h96, 3'd2, 1'b0, 2'b01, 1'b0, 8'h58, 1'b0},
         '{8'h81, 3'd3, 1'b1, 2'b10, 1'b0, 8'h30, 1'b0},
         '{8'hA5, 3'd4, 1'b1, 2'b11, 1'b1, 8'hFA, 1'b0},
         '{8'hFF, 3'd7, 1'b0, 2'b00, 1'b0, 8'h80, 1'b1},
         '{8'h7F, 3'd7, 1'b1, 2'b01, 1'b0, 8'h00, 1'b1},
         '{8'h80, 3'd7, 1'b1, 2'b01, 1'b0, 8'hFF, 1'b0},
         '{8'hA5, 3'd4, 1'b0, 2'b10, 1'b0, 8'h5A, 1'b0}
      };
      bus.out_ready = 1'b1;
      drive(tbl[0], 1'b0);

      // Reset state
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_res", bus.res, 0);
      chk("rst_o", bus.o, 0);
      #11 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", bus.in_ready, 1);

      // Vector table
      foreach (tbl[n]) begin
         run_one(tbl[n], r, ro, lat);
         chk($sformatf("vec%0d_res", n), r, tbl[n].res);
         chk($sformatf("vec%0d_o", n), ro, tbl[n].o);
         if (n == 0) chk("latency", lat, 3);
      end
      @(posedge clk); #1;

      // Reset with beats in flight
      for (int n = 0; n < 3; n++) begin
         drive(tbl[n], 1'b1);
         @(posedge clk); #1;
      end
      drive(tbl[0], 1'b0);
      chk("inflight_valid", bus.out_valid, 1);
      chk("inflight_res", bus.res, 8'h1C);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", bus.out_valid, 0);
      chk("async_rst_res", bus.res, 0);
      chk("async_rst_o", bus.o, 0);
      @(negedge clk) rst_n = 1'b1;
      extra = 0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         if (bus.out_valid) extra++;
      end
      chk("no_stale_beats", extra, 0);
      chk("rst_release_in_ready", bus.in_ready, 1);

      // Chained single-step insert walk
      cur       = 8'hE6;
      walk_bits = 8'hE6;
      for (int n = 0; n < 8; n++) begin
         v = '{cur, 3'd1, 1'b1, 2'b11, 1'b0, 8'h00, 1'b0};
         run_one(v, r, ro, lat);
         chk($sformatf("walk%0d_o", n), ro, walk_bits[n]);
         cur = r;
      end
      chk("walk_final", cur, 8'h00);
      @(posedge clk); #1;

      // Backpressure: out_ready low during cycles 4..7
      sent = 0; rcv = 0; prev_stall = 1'b0; prev_res = '0;
      for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
         bus.out_ready = !(cyc >= 4 && cyc <= 7);
         v = '{8'(sent + 1), 3'd1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
         drive(v, sent < 5);
         @(negedge clk);
         if (cyc >= 4 && cyc <= 7) chk($sformatf("stall_in_ready_c%0d", cyc), bus.in_ready, 0);
         if (prev_stall) chk($sformatf("stall_hold_c%0d", cyc), bus.res, prev_res);
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_res   = bus.res;
         if (bus.out_valid && bus.out_ready) begin
            chk($sformatf("bp_res%0d", rcv), bus.res, 8'((rcv + 1) * 2));
            rcv++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         @(posedge clk); #1;
      end
      chk("bp_count", rcv, 5);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      extra = 0;
      for (int n = 0; n < 5; n++) begin
         if (bus.out_valid) extra++;
         @(posedge clk); #1;
      end
      chk("bp_no_dup", extra, 0);

      // Full throughput: results on cycles 3..7
      sent = 0; rcv = 0;
      for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
         v = '{8'((sent + 1) << 4), 3'd4, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
         drive(v, sent < 5);
         @(negedge clk);
         if (bus.out_valid) begin
            chk($sformatf("tp_res%0d", rcv), bus.res, 8'(rcv + 1));
            chk($sformatf("tp_cycle%0d", rcv), cyc, rcv + 3);
            rcv++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         @(posedge clk); #1;
      end
      chk("tp_count", rcv, 5);
      bus.in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
